// File: rtl/pll_rst_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : pll_rst_pkg                                                |
// | Brief   : Shared types for the PLL reset controller: FSM state       |
// |           encoding, retry counter type and small helper functions.   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package pll_rst_pkg;

  // Encodings are visible on the state output, so they are fixed here.
  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  localparam int RETRY_W = 4;
  typedef logic [RETRY_W-1:0] retry_t;
  localparam retry_t RETRY_MAX = '1;

  // Saturating increment: the retry count sticks at its maximum.
  function automatic retry_t retry_sat_inc(input retry_t value);
    return (value == RETRY_MAX) ? value : retry_t'(value + retry_t'(1));
  endfunction

  // Largest of three cycle counts; sizes the shared cycle counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pll_rst_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : pll_rst_ctrl_if                                            |
// | Brief   : Bundle between the reset controller and the PLL / system:  |
// |           lock in, PLL reset, system reset and status out.           |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
interface pll_rst_ctrl_if;
  import pll_rst_pkg::*;

  logic       lock;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic [1:0] state;
  retry_t     retry_cnt;
  logic       lock_lost;

  // Controller side.
  modport master (
    input  lock,
    output pll_rst, sys_rst, ready, state, retry_cnt, lock_lost
  );

  // PLL / system side.
  modport slave (
    output lock,
    input  pll_rst, sys_rst, ready, state, retry_cnt, lock_lost
  );
endinterface
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sync_2ff                                                   |
// | Brief   : Single-bit two-flop synchronizer, async active-high reset  |
// |           to 0. Output lags the input by two clk edges.              |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module sync_2ff (
  input  wire  clk,
  input  wire  rst,
  input  logic d,
  output logic q
);
  logic r_meta;
  logic r_sync;

  // First flop may go metastable; second flop gives it a cycle to settle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;
endmodule
`default_nettype wire

// File: rtl/pll_rst_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : pll_rst_ctrl                                               |
// | Brief   : Sequences PLL reset, waits for a stable lock, then releases|
// |           the system reset. Retries on lock timeout or lock loss.    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module pll_rst_ctrl
  import pll_rst_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536
) (
  input wire                clk,
  input wire                rst,
  pll_rst_ctrl_if.master    bus
);

  // One counter is shared by all timed states; it only has to hold the
  // largest terminal value (count - 1).
  localparam int MAX_CYC = max3(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] C_PLL_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  retry_t           r_retry;
  retry_t           w_retry_nxt;
  logic             r_lock_lost;
  logic             w_lock_lost_nxt;
  logic             r_pll_rst;
  logic             r_sys_rst;
  logic             r_ready;
  logic             w_lock_s;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.lock),
    .q   (w_lock_s)
  );

  // Next state: counter advances by default and is cleared on every transition.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt + CNT_W'(1);
    w_retry_nxt     = r_retry;
    w_lock_lost_nxt = r_lock_lost;
    case (r_state)
      ST_PLL_RST: begin
        if (r_cnt == C_PLL_LAST) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (w_lock_s) begin
          w_state_nxt = ST_STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_TIMEOUT_LAST) begin
          w_state_nxt = ST_PLL_RST;
          w_cnt_nxt   = '0;
          w_retry_nxt = retry_sat_inc(r_retry);
        end
      end
      ST_STABLE: begin
        // A low lock sample beats a completed stability count.
        if (!w_lock_s) begin
          w_state_nxt = ST_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_STABLE_LAST) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end
      end
      ST_RUN: begin
        w_cnt_nxt = '0;
        if (!w_lock_s) begin
          w_state_nxt     = ST_PLL_RST;
          w_retry_nxt     = retry_sat_inc(r_retry);
          w_lock_lost_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_PLL_RST;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, counter, status and registered outputs; outputs are decoded from
  // the next state so they change on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_PLL_RST;
      r_cnt       <= '0;
      r_retry     <= '0;
      r_lock_lost <= 1'b0;
      r_pll_rst   <= 1'b1;
      r_sys_rst   <= 1'b1;
      r_ready     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_retry     <= w_retry_nxt;
      r_lock_lost <= w_lock_lost_nxt;
      r_pll_rst   <= (w_state_nxt == ST_PLL_RST);
      r_sys_rst   <= (w_state_nxt != ST_RUN);
      r_ready     <= (w_state_nxt == ST_RUN);
    end
  end

  assign bus.pll_rst   = r_pll_rst;
  assign bus.sys_rst   = r_sys_rst;
  assign bus.ready     = r_ready;
  assign bus.state     = r_state;
  assign bus.retry_cnt = r_retry;
  assign bus.lock_lost = r_lock_lost;

endmodule
`default_nettype wire
